// File: rtl/dma_channel_arbiter_pkg.sv
// Shared types and helpers for the DMA channel arbiter.
// Holds the arbiter FSM states, the priority mode encoding and the channel-index wrap helper.
package dma_channel_arbiter_pkg;

    localparam int DMA_MAX_CH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HREQ  = 2'd1,
        ARB_GRANT = 2'd2
    } arb_state_e;

    typedef enum logic {
        FIXED_PRI    = 1'b0,
        ROTATING_PRI = 1'b1
    } priority_mode_e;

    // Next channel index after idx, wrapping at num_ch-1 back to 0.
    function automatic int next_index(input int idx, input int num_ch);
        return (idx + 1 >= num_ch) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dma_channel_arbiter_priority_encoder.sv
// Round-robin capable priority encoder: finds the first set request at or after base,
// wrapping modulo NUM_CH. With base = 0 it behaves as a fixed lowest-index-wins encoder.
module dma_priority_encoder #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] vreq,
    input  logic [CH_W-1:0]   base,
    output logic [CH_W-1:0]   winner,
    output logic              valid
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(base) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!valid && vreq[idx]) begin
                valid  = 1'b1;
                winner = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DREQ/DACK arbiter: samples peripheral requests, raises HRQ, waits for HLDA and grants
// one channel to the transfer timing FSM, with fixed/rotating priority and TC auto-masking.
module dma_channel_arbiter
    import dma_channel_arbiter_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] dreq,
    input  logic [NUM_CH-1:0] dreq_pol,
    input  logic [NUM_CH-1:0] dack_pol,
    input  logic              rot_pri,
    input  logic              ctrl_disable,
    input  logic [NUM_CH-1:0] demand_mode,
    input  logic [NUM_CH-1:0] autoinit,
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_wdata,
    input  logic              smask_we,
    input  logic [CH_W-1:0]   smask_sel,
    input  logic              smask_val,
    input  logic              swreq_we,
    input  logic [CH_W-1:0]   swreq_sel,
    input  logic              swreq_val,
    input  logic              hlda,
    input  logic              svc_end,
    input  logic              tc,
    input  logic              status_rd,
    output logic              hrq,
    output logic [NUM_CH-1:0] dack,
    output logic              active,
    output logic [CH_W-1:0]   active_ch,
    output logic [NUM_CH-1:0] mask_q,
    output logic [NUM_CH-1:0] swreq_q,
    output logic [NUM_CH-1:0] tc_status,
    output arb_state_e        dbg_state,
    output logic [CH_W-1:0]   dbg_rr_ptr
);

    arb_state_e        state_q, state_n;
    priority_mode_e    pri_mode;
    logic [NUM_CH-1:0] dreq_q;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_n;
    logic [CH_W-1:0]   active_ch_n;
    logic [NUM_CH-1:0] mask_n, swreq_wr, swreq_n, tc_status_n;
    logic [NUM_CH-1:0] vreq;
    logic [NUM_CH-1:0] grant_oh;
    logic [CH_W-1:0]   base;
    logic [CH_W-1:0]   win_ch;
    logic              win_vld;
    logic              svc_done, tc_hit, cont;

    assign pri_mode = priority_mode_e'(rot_pri);
    assign base     = (pri_mode == ROTATING_PRI) ? rr_ptr_q : '0;

    // A software request written this cycle already counts, so HRQ follows it by one cycle.
    always_comb begin
        swreq_wr = swreq_q;
        if (swreq_we && (int'(swreq_sel) < NUM_CH)) swreq_wr[swreq_sel] = swreq_val;
    end

    assign vreq = (dreq_q & ~mask_q) | swreq_wr;

    dma_priority_encoder #(.NUM_CH(NUM_CH)) u_enc (
        .vreq   (vreq),
        .base   (base),
        .winner (win_ch),
        .valid  (win_vld)
    );

    assign svc_done = (state_q == ARB_GRANT) && hlda && svc_end;
    assign tc_hit   = svc_done && tc;
    assign cont     = demand_mode[active_ch] && !tc && dreq_q[active_ch] && !mask_q[active_ch];

    always_comb begin
        state_n     = state_q;
        active_ch_n = active_ch;
        rr_ptr_n    = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_vld && !ctrl_disable) state_n = ARB_HREQ;
            end
            ARB_HREQ: begin
                if (!win_vld) begin
                    state_n = ARB_IDLE;
                end else if (hlda) begin
                    state_n     = ARB_GRANT;
                    active_ch_n = win_ch;
                end
            end
            ARB_GRANT: begin
                // Losing HLDA abandons the grant without rotating or recording TC.
                if (!hlda) begin
                    state_n = ARB_IDLE;
                end else if (svc_end && !cont) begin
                    state_n  = ARB_IDLE;
                    rr_ptr_n = CH_W'(next_index(int'(active_ch), NUM_CH));
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // Later writers win: bulk mask write, then single-bit write, then TC auto-mask.
    always_comb begin
        mask_n = mask_q;
        if (mask_we) mask_n = mask_wdata;
        if (smask_we && (int'(smask_sel) < NUM_CH)) mask_n[smask_sel] = smask_val;
        if (tc_hit && !autoinit[active_ch]) mask_n[active_ch] = 1'b1;

        swreq_n = swreq_wr;
        if (tc_hit) swreq_n[active_ch] = 1'b0;

        tc_status_n = status_rd ? '0 : tc_status;
        if (tc_hit) tc_status_n[active_ch] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            dreq_q    <= '0;
            rr_ptr_q  <= '0;
            active_ch <= '0;
            mask_q    <= '1;
            swreq_q   <= '0;
            tc_status <= '0;
        end else begin
            state_q   <= state_n;
            dreq_q    <= dreq ^ dreq_pol;
            rr_ptr_q  <= rr_ptr_n;
            active_ch <= active_ch_n;
            mask_q    <= mask_n;
            swreq_q   <= swreq_n;
            tc_status <= tc_status_n;
        end
    end

    always_comb begin
        grant_oh = '0;
        if (state_q == ARB_GRANT) grant_oh[active_ch] = 1'b1;
    end

    assign hrq        = (state_q != ARB_IDLE);
    assign active     = (state_q == ARB_GRANT);
    assign dack       = grant_oh ^ dack_pol;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: doc/dma_channel_arbiter.md
# dma_channel_arbiter

Parametrised DREQ/DACK request arbiter for the DMA controller, generalising the 4-channel 8237A scheme to NUM_CH channels. It supports per-channel request/acknowledge polarity, fixed or rotating priority, single or demand service per channel, software requests, and auto-masking on terminal count. It sits between the peripheral request pins and the transfer timing FSM: it raises HRQ to the CPU, waits for HLDA, and presents the winning channel to the timing FSM and to the peripheral via DACK.

## Interface
- NUM_CH, 4, channel count, legal range 2..8, need not be a power of two
- CH_W, $clog2(NUM_CH), channel index width (derived, do not override)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dreq  in  NUM_CH  raw request pins
- dreq_pol  in  NUM_CH  1 = channel's DREQ is active-low
- dack_pol  in  NUM_CH  1 = channel's DACK is active-low
- rot_pri  in  1  0 = fixed priority (ch0 highest), 1 = rotating priority
- ctrl_disable  in  1  blocks new arbitration; an active service runs to completion
- demand_mode  in  NUM_CH  1 = demand service, 0 = single service
- autoinit  in  NUM_CH  1 = no auto-mask on TC
- mask_we / mask_wdata  in  1 / NUM_CH  write all mask bits
- smask_we / smask_sel / smask_val  in  1 / CH_W / 1  write a single mask bit
- swreq_we / swreq_sel / swreq_val  in  1 / CH_W / 1  write a single software-request bit
- hlda  in  1  hold acknowledge from the CPU
- svc_end  in  1  one-cycle pulse from the timing FSM at the end of a transfer (S4)
- tc  in  1  terminal count; qualified only with svc_end
- status_rd  in  1  clears tc_status
- hrq  out  1  hold request to the CPU
- dack  out  NUM_CH  acknowledge pins, polarity-adjusted
- active  out  1  a channel is granted
- active_ch  out  CH_W  granted channel index
- mask_q, swreq_q, tc_status  out  NUM_CH  register readback

## Operation
- Request sampling: dreq_q <= dreq ^ dreq_pol, one register stage.
- Valid requests: vreq = (dreq_q & ~mask_q) | swreq_q. Software requests ignore the mask.
- State machine states (ARB_IDLE, ARB_HREQ, ARB_GRANT):
  - IDLE -> HREQ when |vreq and !ctrl_disable.
  - HREQ -> IDLE when vreq == 0.
  - HREQ -> GRANT when hlda = 1 and vreq != 0. The winner is picked in this cycle and latched into active_ch.
  - GRANT -> IDLE when hlda drops. There is no rotation, no TC update, and dack releases in the next cycle.
  - On svc_end in GRANT: stay in GRANT only if demand_mode[ch], !tc and dreq_q[ch] & ~mask_q[ch]. Otherwise go to IDLE.
- Priority:
  - Fixed mode: lowest index wins.
  - Rotating mode: the search starts at rr_ptr and wraps modulo NUM_CH. On every GRANT->IDLE exit via svc_end, rr_ptr <= (active_ch + 1), with wrap at NUM_CH-1 -> 0.
  - rot_pri changes take effect at the next arbitration. rr_ptr is kept in fixed mode.
- On svc_end with tc for channel ch:
  - tc_status[ch] <= 1
  - swreq_q[ch] <= 0
  - if !autoinit[ch], mask_q[ch] <= 1
- Mask update precedence within one cycle: mask_we, then smask_we, then the TC auto-mask (later ones win).
- tc_status: a TC set and status_rd in the same cycle leave the bit set.
- Masking the active channel during GRANT does not abort the service. The mask only affects the svc_end continuation decision.
- Outputs:
  - hrq = (state != IDLE)
  - active = (state == GRANT)
  - dack = (active ? onehot(active_ch) : 0) ^ dack_pol

## Timing
- Reset values:
  - state IDLE, rr_ptr 0
  - mask_q all ones, swreq_q 0, tc_status 0, dreq_q 0
  - hrq 0, active 0, active_ch 0, dack = dack_pol
- Latency: a DREQ edge at cycle 0 gives dreq_q in cycle 1 and hrq in cycle 2.
- hlda high in cycle n gives dack/active in cycle n+1.
- svc_end in cycle m:
  - Single service: dack and hrq drop in cycle m+1.
  - Demand continuation: no gap on dack.
- A software request written in cycle 0 gives hrq in cycle 1.
- Reset asserted mid-GRANT forces the reset values immediately (asynchronous).

## Structure
- DmaPackage adds:
  - enum ARB_STATE_e {ARB_IDLE, ARB_HREQ, ARB_GRANT}
  - enum PRIORITY_MODE_e {FIXED_PRI, ROTATING_PRI}
  - constant DMA_MAX_CH = 8
- Sub-module dma_priority_encoder (combinational, NUM_CH-parametrised): inputs are vreq and the base index; outputs are the winner index and a valid flag.

## Test plan
- NUM_CH=4, fixed priority, mask 0, dreq = 0110, hlda two cycles after hrq -> active_ch = 1, dack = 0010, hrq rises 2 cycles after dreq.
- Rotating priority, requests on ch0..3 held, 4 single services -> grants in order 0,1,2,3. Then ch3 serviced -> rr_ptr = 0.
- NUM_CH=5, rotating priority, ch4 serviced -> rr_ptr wraps to 0. dack_pol = 10101 idle -> dack = 10101.
- Demand mode on ch2 with dreq held for 3 svc_end pulses, tc on the third -> dack continuous, drops after the third. mask_q[2] = 1 when autoinit = 0. tc_status = 00100.
- hlda dropped mid-GRANT -> dack released next cycle, tc_status and rr_ptr unchanged. status_rd together with tc -> bit stays set.
- Software request on masked ch3 -> granted. swreq_q[3] is cleared by svc_end with tc.
